// File: rtl/sm_muldiv.sv
// sm_muldiv: iterative MIPS-style multiply/divide unit with a HI/LO register pair
//   clk, rst_n      clock (rising edge), asynchronous active-low reset
//   start, oper     command strobe and opcode (0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO)
//   srcA, srcB      operands (srcA also carries MTHI/MTLO data)
//   flush           abort of an in-flight mul/div
//   busy, done      in-flight flag and one-cycle completion pulse
//   divZero         sticky divide-by-zero flag
//   hi, lo          HI/LO registers
module sm_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       oper,
    input  logic [WIDTH-1:0] srcA,
    input  logic [WIDTH-1:0] srcB,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic             divZero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX} stateT;
    stateT state, nextState;
    logic [CW-1:0] counter;
    logic isDiv, signA, signB, zeroDiv, accept, signedOp;
    logic [WIDTH-1:0] operand, absA, absB, quot, rem, diff;
    logic [2*WIDTH-1:0] acc, accNext, prod, result;
    logic [WIDTH:0] mulSum, shifted;
    assign busy = state != IDLE;
    assign accept = state == IDLE && start && !oper[2];
    assign signedOp = !oper[0];
    assign absA = signedOp && srcA[WIDTH-1] ? -srcA : srcA;
    assign absB = signedOp && srcB[WIDTH-1] ? -srcB : srcB;
    // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide
    always_comb begin
        mulSum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        shifted = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        diff = shifted[WIDTH-1:0] - operand;
        accNext = !isDiv ? {mulSum, acc[WIDTH-1:1]} :
                  shifted >= {1'b0, operand} ? {diff, acc[WIDTH-2:0], 1'b1} :
                  {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        prod = signA ^ signB ? -acc : acc;
        quot = signA ^ signB ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem = signA ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
        // zero divisor leaves |srcA| in the remainder, so the signed fix-up restores the original srcA
        result = isDiv ? {rem, zeroDiv ? {WIDTH{1'b1}} : quot} : prod;
    end
    always_comb begin
        nextState = state;
        if (accept)
            nextState = CALC;
        else if (state != IDLE && flush)
            nextState = IDLE;
        else if (state == CALC && counter == '0)
            nextState = FIX;
        else if (state == FIX)
            nextState = IDLE;
    end
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= nextState;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            counter <= '0;
            isDiv <= 1'b0;
            signA <= 1'b0;
            signB <= 1'b0;
            zeroDiv <= 1'b0;
            operand <= '0;
            acc <= '0;
            done <= 1'b0;
            divZero <= 1'b0;
            hi <= '0;
            lo <= '0;
        end else begin
            done <= 1'b0;
            if (accept) begin
                isDiv <= oper[1];
                signA <= signedOp && srcA[WIDTH-1];
                signB <= signedOp && srcB[WIDTH-1];
                zeroDiv <= oper[1] && srcB == '0;
                operand <= oper[1] ? absB : absA;
                acc <= oper[1] ? {{WIDTH{1'b0}}, absA} : {{WIDTH{1'b0}}, absB};
                counter <= CW'(WIDTH - 1);
                divZero <= 1'b0;
            end else if (state == IDLE && start && oper == 3'd4) begin
                hi <= srcA;
            end else if (state == IDLE && start && oper == 3'd5) begin
                lo <= srcA;
            end else if (state == CALC && !flush) begin
                acc <= accNext;
                counter <= counter - 1'b1;
            end else if (state == FIX && !flush) begin
                {hi, lo} <= result;
                done <= 1'b1;
                divZero <= zeroDiv;
            end
        end
    end
endmodule

// File: tb/tb_sm_muldiv.sv
// tb_sm_muldiv: randomized self-checking bench for sm_muldiv against an arithmetic reference model
module tb_sm_muldiv;
    logic clk = 1'b0, rst_n, start, flush, busy, done, divZero;
    logic [2:0] oper;
    logic [31:0] srcA, srcB, hi, lo;
    logic [31:0] mHi, mLo;
    logic mDz;
    int checks = 0, failures = 0;
    sm_muldiv #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .oper(oper), .srcA(srcA), .srcB(srcB),
        .flush(flush), .busy(busy), .done(done), .divZero(divZero), .hi(hi), .lo(lo)
    );
    always #5 clk = ~clk;
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask
    // reference: plain 64-bit arithmetic, SV division truncates toward zero like MIPS
    task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p, q, r;
        mDz = 1'b0;
        if (op == 3'd0) begin
            p = longint'($signed(a)) * longint'($signed(b));
            {mHi, mLo} = p;
        end else if (op == 3'd1) begin
            p = {32'b0, a} * {32'b0, b};
            {mHi, mLo} = p;
        end else if (b == 32'd0) begin
            mLo = 32'hFFFFFFFF;
            mHi = a;
            mDz = 1'b1;
        end else if (op == 3'd2) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
            mLo = q[31:0];
            mHi = r[31:0];
        end else begin
            mLo = a / b;
            mHi = a % b;
        end
    endtask
    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        @(negedge clk);
        start = 1'b1;
        oper = op;
        srcA = a;
        srcB = b;
        flush = fl;
        @(negedge clk);
        start = 1'b0;
        flush = 1'b0;
    endtask
    task automatic waitDone(output int cyc);
        cyc = 0;
        while (busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
    endtask
    task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic fl);
        int cyc;
        issue(op, a, b, fl);
        model(op, a, b);
        waitDone(cyc);
        check("busy_cycles", 64'(cyc), 64'd33);
        check("done_pulse", {63'b0, done}, 64'd1);
        check("hi", {32'b0, hi}, {32'b0, mHi});
        check("lo", {32'b0, lo}, {32'b0, mLo});
        check("divZero", {63'b0, divZero}, {63'b0, mDz});
        @(negedge clk);
        check("done_low", {63'b0, done}, 64'd0);
    endtask
    function automatic logic [31:0] pick();
        int r = $urandom_range(0, 7);
        return r == 0 ? 32'd0 : r == 1 ? 32'h80000000 : r == 2 ? 32'hFFFFFFFF :
               r == 3 ? 32'($urandom_range(0, 20)) : 32'($urandom);
    endfunction
    initial begin
        int cyc;
        rst_n = 1'b0;
        start = 1'b0;
        flush = 1'b0;
        oper = 3'd0;
        srcA = '0;
        srcB = '0;
        mHi = '0;
        mLo = '0;
        mDz = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_done", {63'b0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_dz", {63'b0, divZero}, 64'd0);
        rst_n = 1'b1;
        runOp(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
        check("multu_lit", {hi, lo}, 64'hFFFFFFFE_00000001);
        runOp(3'd0, 32'hFFFFFFFD, 32'd7, 1'b0);
        check("mult_lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFEB);
        runOp(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check("div_lit", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        runOp(3'd3, 32'd100, 32'd0, 1'b0);
        check("divu0_lit", {hi, lo, 31'b0, divZero}, {64'h00000064_FFFFFFFF, 32'd1});
        runOp(3'd3, 32'd100, 32'd7, 1'b0);
        check("divu_lit", {hi, lo, 31'b0, divZero}, {64'h00000002_0000000E, 32'd0});
        runOp(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check("div_ovf_lit", {hi, lo}, 64'h00000000_80000000);
        // MTHI in IDLE
        issue(3'd4, 32'h12345678, 32'd0, 1'b0);
        mHi = 32'h12345678;
        check("mthi_hi", {32'b0, hi}, {32'b0, mHi});
        check("mthi_busy_done", {62'b0, busy, done}, 64'd0);
        // reserved opcode is a no-op
        issue(3'd6, 32'hDEADBEEF, 32'd3, 1'b0);
        check("rsvd_busy", {63'b0, busy}, 64'd0);
        check("rsvd_hilo", {hi, lo}, {mHi, mLo});
        // MTLO while busy is ignored
        issue(3'd1, 32'd12345, 32'd678, 1'b0);
        model(3'd1, 32'd12345, 32'd678);
        repeat (3) @(negedge clk);
        start = 1'b1;
        oper = 3'd5;
        srcA = 32'hCAFEF00D;
        @(negedge clk);
        start = 1'b0;
        waitDone(cyc);
        check("mtlo_busy_done", {63'b0, done}, 64'd1);
        check("mtlo_busy_lo", {32'b0, lo}, {32'b0, mLo});
        // flush mid-CALC: no done, HI/LO untouched, then an immediate new op
        issue(3'd1, 32'hABCDEF01, 32'h13572468, 1'b0);
        repeat (9) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", {63'b0, busy}, 64'd0);
        check("flush_done", {63'b0, done}, 64'd0);
        check("flush_hilo", {hi, lo}, {mHi, mLo});
        runOp(3'd0, 32'h7FFFFFFF, 32'h80000000, 1'b0);
        // flush together with start in IDLE: start wins
        runOp(3'd3, 32'hFFFFFFF0, 32'd9, 1'b1);
        // async reset mid-CALC
        issue(3'd1, 32'hFFFFFFFF, 32'h12345678, 1'b0);
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("amid_busy_done", {62'b0, busy, done}, 64'd0);
        check("amid_hilo", {hi, lo}, 64'd0);
        mHi = '0;
        mLo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 40; i++)
            runOp(3'($urandom_range(0, 3)), pick(), pick(), $urandom_range(0, 7) == 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
